checkpoint_seq_monitor: RTL and testbench
=========================================

CHECKPOINT_SEQ_MONITOR -- requirements
Module: checkpoint_seq_monitor

Interface
REQ-001 SHALL have parameter W, default 16, meaning checkpoint bus width.
REQ-002 SHALL have parameter N, default 8, meaning expected-table depth, 1..64.
REQ-003 SHALL have parameter TW, default 32, meaning timeout counter width.
REQ-004 SHALL have parameters START_CODE, default 16'hAB40, and END_CODE, default 16'hAB51; both are W bits wide.
REQ-005 SHALL provide the following ports, clock and reset first:
- clock  in  1  sole clock; one clock; reset is synchronous and active-low.
- resetb  in  1  synchronous active-low reset.
- probe  in  W  observed checkpoint bus, e.g. mprj_io[31:16].
- exp_we  in  1  expected-table write strobe.
- exp_addr  in  clog2(N)  write index.
- exp_data  in  W  write value.
- exp_count  in  clog2(N)+1  number of checkpoints to match, 0..N.
- strict  in  1  1 = any unexpected new value fails the run.
- timeout_limit  in  TW  maximum idle cycles between advances; 0 = disabled.
- restart  in  1  pulse; aborts the run and returns to IDLE.
- busy  out  1  state is RUN or WAIT_END.
- pass  out  1  sticky; sequence completed.
- fail  out  1  sticky; run failed.
- fail_code  out  2  01 timeout, 10 mismatch, 11 early END, 00 none.
- match_pulse  out  1  one-cycle strobe per matched checkpoint.
- match_idx  out  clog2(N)+1  number of checkpoints matched so far.

Function
REQ-006 SHALL register probe into probe_q and probe_q into probe_qq; a "new-value event" is defined as probe_q != probe_qq.
REQ-007 SHALL evaluate all matching only on new-value events; a value held on the bus SHALL count once.
REQ-008 SHALL implement the FSM states IDLE, RUN, WAIT_END, PASS and FAIL.
REQ-009 IDLE: an event equal to START_CODE SHALL go to RUN, or to WAIT_END if exp_count==0; the timer and match_idx SHALL clear.
REQ-010 RUN: an event equal to exp[match_idx] SHALL pulse match_pulse, increment match_idx and clear the timer; when match_idx reaches exp_count, the FSM SHALL go to WAIT_END.
REQ-011 RUN: an event equal to END_CODE (not the expected value) SHALL go to FAIL, code 11, in both modes.
REQ-012 RUN and WAIT_END with strict=1: any other event SHALL go to FAIL, code 10; with strict=0 such events SHALL be ignored.
REQ-013 WAIT_END: an event equal to END_CODE SHALL go to PASS.
REQ-014 The timer SHALL increment every cycle in RUN and WAIT_END; when it equals a nonzero timeout_limit, the FSM SHALL go to FAIL, code 01.
REQ-015 PASS and FAIL SHALL hold until restart or reset.
REQ-016 restart SHALL go to IDLE from any state, clearing pass, fail, fail_code, match_idx and the timer; the expected table SHALL be preserved.
REQ-017 Simultaneous events: restart beats everything; a match or END beats timeout in the same cycle; mismatch beats timeout.
REQ-018 exp_we SHALL be accepted only in IDLE, PASS or FAIL, and SHALL be ignored while busy; exp_we in the restart cycle SHALL be accepted.
REQ-019 Latency: a bus value presented before edge k SHALL produce match_pulse, state and flags visible after edge k+2.
REQ-020 All outputs SHALL be registered; exp_count > N SHALL be treated as N.

Reset
REQ-021 While resetb==0 at a clock edge, the block SHALL enter IDLE and clear busy, pass, fail, fail_code, match_pulse, match_idx, the timer, probe_q, probe_qq and all table entries to 0.
REQ-022 Reset asserted mid-run SHALL abort the run with no pass or fail reported.

Structure
REQ-023 Package checkpoint_mon_pkg SHALL hold the state enum, the fail_code constants and the default START and END codes.
REQ-024 The block SHALL contain one sub-module, checkpoint_exp_table: an N x W register file with synchronous write and combinational read.

Verification
REQ-025 Run exp={003E,0044,004A,0050}, count=4, strict=1, probe sequence AB40,003E,0044,004A,0050,AB51 -> four match_pulses, match_idx=4, pass=1, fail_code=00.
REQ-026 Same setup, with 1234 inserted after 0044 -> strict=1: fail=1, code 10, match_idx=2; strict=0: pass=1.
REQ-027 timeout_limit=100, bus stuck at 0044 after the second match -> fail=1, code 01, exactly 100 cycles after the 0044 match cycle.
REQ-028 AB51 driven after 003E -> fail=1, code 11, match_idx=1; then restart -> IDLE with the table intact, and a rerun of REQ-025 passes.
REQ-029 exp={0007,0007}: bus 0007,0008,0007 counts two matches; bus 0007 held counts one match.
REQ-030 Reset pulsed mid-RUN, and exp_we pulsed while busy -> outputs zero after reset, and the table is unchanged by the busy write.

Source files
------------

// File: rtl/checkpoint_mon_pkg.sv
// Shared definitions for the checkpoint sequence monitor: FSM states,
// failure codes and the default start/end marker values.
package checkpoint_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_END,
    ST_PASS,
    ST_FAIL
  } mon_state_t;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_TIMEOUT   = 2'b01;
  localparam logic [1:0] FC_MISMATCH  = 2'b10;
  localparam logic [1:0] FC_EARLY_END = 2'b11;

  localparam logic [15:0] DEFAULT_START_CODE = 16'hAB40;
  localparam logic [15:0] DEFAULT_END_CODE   = 16'hAB51;

endpackage

// File: rtl/checkpoint_exp_table.sv
// Expected-checkpoint register file: synchronous write, combinational read,
// cleared by the synchronous active-low reset.
module checkpoint_exp_table #(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clock) begin
    if (!resetb) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Watches a checkpoint bus for START, an ordered list of expected values and
// END, reporting sticky pass/fail with a failure code and a per-cycle timeout.
module checkpoint_seq_monitor
  import checkpoint_mon_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int TW = 32,
  parameter logic [W-1:0] START_CODE = W'(DEFAULT_START_CODE),
  parameter logic [W-1:0] END_CODE   = W'(DEFAULT_END_CODE),
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic [W-1:0]  probe,
  input  logic          exp_we,
  input  logic [AW-1:0] exp_addr,
  input  logic [W-1:0]  exp_data,
  input  logic [CW-1:0] exp_count,
  input  logic          strict,
  input  logic [TW-1:0] timeout_limit,
  input  logic          restart,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic          match_pulse,
  output logic [CW-1:0] match_idx
);

  mon_state_t    state;
  logic [W-1:0]  probe_q, probe_qq, ev_value, exp_value;
  logic          ev_valid, in_busy, table_we, timed_out;
  logic [TW-1:0] timer;
  logic [CW-1:0] eff_count, next_idx;

  assign in_busy   = (state == ST_RUN) || (state == ST_WAIT_END);
  assign table_we  = exp_we && (restart || !in_busy);
  assign eff_count = (exp_count > CW'(N)) ? CW'(N) : exp_count;
  assign next_idx  = match_idx + CW'(1);
  assign timed_out = (timeout_limit != '0) && ((timer + TW'(1)) == timeout_limit);

  checkpoint_exp_table #(.W(W), .N(N), .AW(AW)) u_exp_table (
    .clock   (clock),
    .resetb  (resetb),
    .we      (table_we),
    .wr_addr (exp_addr),
    .wr_data (exp_data),
    .rd_addr (match_idx[AW-1:0]),
    .rd_data (exp_value)
  );

  // Event stage is registered so the FSM acts two edges after the bus sample.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      probe_q  <= '0;
      probe_qq <= '0;
      ev_valid <= 1'b0;
      ev_value <= '0;
    end else begin
      probe_q  <= probe;
      probe_qq <= probe_q;
      ev_valid <= (probe_q != probe_qq);
      ev_value <= probe_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb || restart) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= FC_NONE;
      match_pulse <= 1'b0;
      match_idx   <= '0;
      timer       <= '0;
    end else begin
      match_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ev_valid && ev_value == START_CODE) begin
            timer     <= '0;
            match_idx <= '0;
            busy      <= 1'b1;
            state     <= (eff_count == '0) ? ST_WAIT_END : ST_RUN;
          end
        end
        ST_RUN: begin
          timer <= timer + TW'(1);
          if (ev_valid && ev_value == exp_value) begin
            match_pulse <= 1'b1;
            match_idx   <= next_idx;
            timer       <= '0;
            if (next_idx >= eff_count) state <= ST_WAIT_END;
          end else if (ev_valid && ev_value == END_CODE) begin
            state <= ST_FAIL; fail <= 1'b1; busy <= 1'b0; fail_code <= FC_EARLY_END;
          end else if (ev_valid && strict) begin
            state <= ST_FAIL; fail <= 1'b1; busy <= 1'b0; fail_code <= FC_MISMATCH;
          end else if (timed_out) begin
            state <= ST_FAIL; fail <= 1'b1; busy <= 1'b0; fail_code <= FC_TIMEOUT;
          end
        end
        ST_WAIT_END: begin
          timer <= timer + TW'(1);
          if (ev_valid && ev_value == END_CODE) begin
            state <= ST_PASS; pass <= 1'b1; busy <= 1'b0;
          end else if (ev_valid && strict) begin
            state <= ST_FAIL; fail <= 1'b1; busy <= 1'b0; fail_code <= FC_MISMATCH;
          end else if (timed_out) begin
            state <= ST_FAIL; fail <= 1'b1; busy <= 1'b0; fail_code <= FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed scenarios for checkpoint_seq_monitor with hand-computed expectations.
module tb_checkpoint_seq_monitor;

  logic        clock = 1'b0;
  logic        resetb;
  logic [15:0] probe;
  logic        exp_we;
  logic [2:0]  exp_addr;
  logic [15:0] exp_data;
  logic [3:0]  exp_count;
  logic        strict;
  logic [31:0] timeout_limit;
  logic        restart;
  logic        busy, pass, fail, match_pulse;
  logic [1:0]  fail_code;
  logic [3:0]  match_idx;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  logic [15:0] seq_buf [8];
  logic [15:0] tab_buf [4];

  checkpoint_seq_monitor dut (
    .clock         (clock),
    .resetb        (resetb),
    .probe         (probe),
    .exp_we        (exp_we),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .exp_count     (exp_count),
    .strict        (strict),
    .timeout_limit (timeout_limit),
    .restart       (restart),
    .busy          (busy),
    .pass          (pass),
    .fail          (fail),
    .fail_code     (fail_code),
    .match_pulse   (match_pulse),
    .match_idx     (match_idx)
  );

  always #5 clock = ~clock;

  // Advance to the next falling edge, tallying match pulses along the way.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (match_pulse === 1'b1) pulse_cnt++;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(1);
    pulse_cnt = 0;
  endtask

  task automatic load_table(input int n);
    for (int i = 0; i < n; i++) begin
      exp_we = 1'b1;
      exp_addr = 3'(i);
      exp_data = tab_buf[i];
      step(1);
    end
    exp_we = 1'b0;
  endtask

  task automatic drive_seq(input int len);
    for (int i = 0; i < len; i++) begin
      probe = seq_buf[i];
      step(1);
    end
    step(2);
  endtask

  task automatic set_basic_seq();
    seq_buf = '{16'hAB40, 16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB51, 16'h0, 16'h0};
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    step(2);
    resetb = 1'b1;
    step(1);
    vectors++;
    if ({busy, pass, fail, fail_code, match_pulse, match_idx} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b expected %b",
               {busy, pass, fail, fail_code, match_pulse, match_idx}, 10'b0);
    end
  endtask

  task automatic test_basic();
    tab_buf = '{16'h003E, 16'h0044, 16'h004A, 16'h0050};
    load_table(4);
    exp_count = 4'd4;
    strict = 1'b1;
    pulse_cnt = 0;
    set_basic_seq();
    drive_seq(6);
    vectors++;
    if (pulse_cnt !== 4) begin
      miscompares++;
      $display("[TB] FAIL basic_pulses: got %0d expected 4", pulse_cnt);
    end
    vectors++;
    if ({busy, pass, fail, fail_code, match_idx} !== {1'b0, 1'b1, 1'b0, 2'b00, 4'd4}) begin
      miscompares++;
      $display("[TB] FAIL basic_flags: got %b expected %b",
               {busy, pass, fail, fail_code, match_idx}, {1'b0, 1'b1, 1'b0, 2'b00, 4'd4});
    end
  endtask

  task automatic test_mismatch();
    do_restart();
    strict = 1'b1;
    seq_buf = '{16'hAB40, 16'h003E, 16'h0044, 16'h1234, 16'h004A, 16'h0050, 16'hAB51, 16'h0};
    drive_seq(7);
    vectors++;
    if ({pass, fail, fail_code, match_idx} !== {1'b0, 1'b1, 2'b10, 4'd2}) begin
      miscompares++;
      $display("[TB] FAIL strict_mismatch: got %b expected %b",
               {pass, fail, fail_code, match_idx}, {1'b0, 1'b1, 2'b10, 4'd2});
    end
    do_restart();
    strict = 1'b0;
    drive_seq(7);
    vectors++;
    if ({pass, fail, fail_code, match_idx} !== {1'b1, 1'b0, 2'b00, 4'd4}) begin
      miscompares++;
      $display("[TB] FAIL lenient_mismatch: got %b expected %b",
               {pass, fail, fail_code, match_idx}, {1'b1, 1'b0, 2'b00, 4'd4});
    end
    vectors++;
    if (pulse_cnt !== 4) begin
      miscompares++;
      $display("[TB] FAIL lenient_pulses: got %0d expected 4", pulse_cnt);
    end
  endtask

  task automatic test_timeout();
    do_restart();
    strict = 1'b1;
    timeout_limit = 32'd100;
    probe = 16'hAB40;
    step(1);
    probe = 16'h003E;
    step(1);
    probe = 16'h0044;
    step(3);
    vectors++;
    if ({match_pulse, match_idx} !== {1'b1, 4'd2}) begin
      miscompares++;
      $display("[TB] FAIL timeout_second_match: got %b expected %b",
               {match_pulse, match_idx}, {1'b1, 4'd2});
    end
    step(99);
    vectors++;
    if ({busy, fail} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL timeout_not_early: got %b expected %b", {busy, fail}, 2'b10);
    end
    step(1);
    vectors++;
    if ({busy, fail, fail_code} !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL timeout_fire: got %b expected %b", {busy, fail, fail_code}, 4'b0101);
    end
    vectors++;
    if (match_idx !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL timeout_idx: got %0d expected 2", match_idx);
    end
    timeout_limit = 32'd0;
  endtask

  task automatic test_early_end();
    do_restart();
    strict = 1'b1;
    seq_buf = '{16'hAB40, 16'h003E, 16'hAB51, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    drive_seq(3);
    vectors++;
    if ({pass, fail, fail_code, match_idx} !== {1'b0, 1'b1, 2'b11, 4'd1}) begin
      miscompares++;
      $display("[TB] FAIL early_end: got %b expected %b",
               {pass, fail, fail_code, match_idx}, {1'b0, 1'b1, 2'b11, 4'd1});
    end
    do_restart();
    vectors++;
    if ({busy, pass, fail, fail_code, match_idx} !== 9'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_idle: got %b expected %b",
               {busy, pass, fail, fail_code, match_idx}, 9'b0);
    end
    set_basic_seq();
    drive_seq(6);
    vectors++;
    if ({pass, fail, match_idx} !== {1'b1, 1'b0, 4'd4} || pulse_cnt !== 4) begin
      miscompares++;
      $display("[TB] FAIL rerun_after_restart: got %b pulses %0d expected %b pulses 4",
               {pass, fail, match_idx}, pulse_cnt, {1'b1, 1'b0, 4'd4});
    end
  endtask

  task automatic test_zero_count();
    do_restart();
    exp_count = 4'd0;
    probe = 16'hAB40;
    step(2);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL latency_early: got %b expected 0", busy);
    end
    step(1);
    vectors++;
    if ({busy, match_idx} !== {1'b1, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL latency_start: got %b expected %b", {busy, match_idx}, {1'b1, 4'd0});
    end
    probe = 16'hAB51;
    step(3);
    vectors++;
    if ({busy, pass, fail, match_idx} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL zero_count_pass: got %b expected %b",
               {busy, pass, fail, match_idx}, {1'b0, 1'b1, 1'b0, 4'd0});
    end
  endtask

  task automatic test_repeat();
    do_restart();
    tab_buf = '{16'h0007, 16'h0007, 16'h0, 16'h0};
    load_table(2);
    exp_count = 4'd2;
    strict = 1'b0;
    pulse_cnt = 0;
    seq_buf = '{16'hAB40, 16'h0007, 16'h0008, 16'h0007, 16'hAB51, 16'h0, 16'h0, 16'h0};
    drive_seq(5);
    vectors++;
    if ({pass, match_idx} !== {1'b1, 4'd2} || pulse_cnt !== 2) begin
      miscompares++;
      $display("[TB] FAIL repeat_toggled: got %b pulses %0d expected %b pulses 2",
               {pass, match_idx}, pulse_cnt, {1'b1, 4'd2});
    end
    do_restart();
    probe = 16'hAB40;
    step(1);
    probe = 16'h0007;
    step(6);
    vectors++;
    if ({busy, pass, match_idx} !== {1'b1, 1'b0, 4'd1} || pulse_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL repeat_held: got %b pulses %0d expected %b pulses 1",
               {busy, pass, match_idx}, pulse_cnt, {1'b1, 1'b0, 4'd1});
    end
  endtask

  task automatic test_table_write();
    exp_we = 1'b1;
    exp_addr = 3'd0;
    exp_data = 16'h0055;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    exp_we = 1'b0;
    step(1);
    exp_count = 4'd1;
    strict = 1'b1;
    seq_buf = '{16'hAB40, 16'h0055, 16'hAB51, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    drive_seq(3);
    vectors++;
    if ({pass, fail, match_idx} !== {1'b1, 1'b0, 4'd1}) begin
      miscompares++;
      $display("[TB] FAIL restart_cycle_write: got %b expected %b",
               {pass, fail, match_idx}, {1'b1, 1'b0, 4'd1});
    end
  endtask

  task automatic test_reset_mid_run();
    do_restart();
    probe = 16'hAB40;
    step(3);
    exp_we = 1'b1;
    exp_addr = 3'd0;
    exp_data = 16'h0099;
    step(1);
    exp_we = 1'b0;
    probe = 16'h0055;
    step(3);
    vectors++;
    if ({busy, fail, match_pulse, match_idx} !== {1'b1, 1'b0, 1'b1, 4'd1}) begin
      miscompares++;
      $display("[TB] FAIL busy_write_ignored: got %b expected %b",
               {busy, fail, match_pulse, match_idx}, {1'b1, 1'b0, 1'b1, 4'd1});
    end
    resetb = 1'b0;
    step(1);
    resetb = 1'b1;
    step(1);
    vectors++;
    if ({busy, pass, fail, fail_code, match_pulse, match_idx} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_run: got %b expected %b",
               {busy, pass, fail, fail_code, match_pulse, match_idx}, 10'b0);
    end
    seq_buf = '{16'hAB40, 16'h0000, 16'hAB51, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    drive_seq(3);
    vectors++;
    if ({pass, fail, match_idx} !== {1'b1, 1'b0, 4'd1}) begin
      miscompares++;
      $display("[TB] FAIL table_cleared_by_reset: got %b expected %b",
               {pass, fail, match_idx}, {1'b1, 1'b0, 4'd1});
    end
  endtask

  initial begin
    resetb = 1'b0;
    probe = 16'h0;
    exp_we = 1'b0;
    exp_addr = 3'd0;
    exp_data = 16'h0;
    exp_count = 4'd0;
    strict = 1'b0;
    timeout_limit = 32'd0;
    restart = 1'b0;
    test_reset();
    test_basic();
    test_mismatch();
    test_timeout();
    test_early_end();
    test_zero_count();
    test_repeat();
    test_table_write();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
